// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: queued single transfers, pipelined address/data phases.
// Optional AHB_MGR_ERR_FLUSH_EN: flush the queue with error responses after a bus error.
module ahb_lite_manager #(
  parameter int QDEPTH = 4,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [2:0]    cmd_size,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_error,
  output logic          hsel,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [31:0]   hwdata,
  input  logic          hready,
  input  logic [31:0]   hrdata,
  input  logic          hresp
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
`ifdef AHB_MGR_ERR_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [31:0]   wdata;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, ERR1, ERR2
  } state_t;

  state_t        state;
  cmd_t          mem [QDEPTH];
  cmd_t          cmd_in;
  cmd_t          cand;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] cand_idx;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          adv;
  logic          a_vld;
  logic          cand_ok;
  logic          head_bad;
  logic          ld;
  logic          a_drop;
  logic          d_write;
  logic [31:0]   a_wdata;

  function automatic logic legal(input cmd_t c);
    unique case (c.size)
      3'd0:    return 1'b1;
      3'd1:    return ~c.addr[0];
      3'd2:    return c.addr[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  assign cmd_in    = {cmd_write, cmd_addr, cmd_size, cmd_wdata};
  assign cmd_ready = (count < CW'(QDEPTH)) && !(FLUSH && state == ERR2);
  assign push      = cmd_valid & cmd_ready;
  assign a_vld     = htrans[1];
  assign hsel      = htrans[1];
  assign hburst    = 3'b000;

  // The address-phase command stays queued until it reaches the data phase,
  // so a cancelled address phase simply reissues from the head.
  assign adv      = a_vld & hready & (state == ADDR || state == DATA);
  assign cand_idx = rd_ptr + PW'(adv);
  assign cand     = mem[cand_idx];
  assign cand_ok  = (count > CW'(adv)) && legal(cand);
  assign head_bad = (count != '0) && !legal(mem[rd_ptr]);

  always_comb begin
    pop    = 1'b0;
    ld     = 1'b0;
    a_drop = 1'b0;
    unique case (state)
      IDLE: begin
        pop = head_bad;
        ld  = cand_ok;
      end
      ADDR, DATA: begin
        pop = adv;
        if (hready) begin
          ld     = cand_ok;
          a_drop = 1'b1;
        end else if (state == DATA && hresp) begin
          a_drop = 1'b1;
        end else if (!a_vld) begin
          ld = cand_ok;
        end
      end
      ERR2: begin
        pop = FLUSH ? (count != '0) : head_bad;
        ld  = !FLUSH && cand_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      htrans  <= T_IDLE;
      haddr   <= '0;
      hwrite  <= 1'b0;
      hsize   <= 3'd0;
      a_wdata <= '0;
    end else if (ld) begin
      htrans  <= T_NSEQ;
      haddr   <= cand.addr;
      hwrite  <= cand.write;
      hsize   <= cand.size;
      a_wdata <= cand.wdata;
    end else if (a_drop) begin
      htrans  <= T_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      d_write   <= 1'b0;
      hwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (cand_ok) begin
            state <= ADDR;
          end else if (head_bad) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
          end
        end
        ADDR: begin
          if (hready) begin
            d_write <= hwrite;
            hwdata  <= a_wdata;
            state   <= DATA;
          end
        end
        DATA: begin
          if (hready) begin
            rsp_valid <= 1'b1;
            rsp_error <= hresp;
            if (!d_write && !hresp) rsp_rdata <= hrdata;
            if (a_vld) begin
              d_write <= hwrite;
              hwdata  <= a_wdata;
            end else begin
              state <= cand_ok ? ADDR : IDLE;
            end
          end else if (hresp) begin
            state <= ERR1;
          end
        end
        ERR1: begin
          if (hready) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            state     <= ERR2;
          end
        end
        ERR2: begin
          if (FLUSH) begin
            if (count != '0) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (cand_ok) begin
            state <= ADDR;
          end else begin
            state <= IDLE;
            if (head_bad) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Bench for ahb_lite_manager: scoreboarded responses against a small
// AHB-Lite subordinate with programmable wait states and error responses.
`timescale 1ns/1ps
module tb_ahb_lite_manager;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready = 1'b1;
  logic [31:0] hrdata = '0;
  logic        hresp = 1'b0;

  ahb_lite_manager #(.QDEPTH(4), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hready(hready),
    .hrdata(hrdata), .hresp(hresp)
  );

  always #5 clk = ~clk;

`ifdef AHB_MGR_ERR_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { int waits; bit err; } cfg_t;
  typedef struct { logic [3:0] addr; logic w; logic [2:0] size; int cyc; } xfer_t;

  rsp_t  exp_q[$];
  int    rsp_cyc_q[$];
  cfg_t  cfg_q[$];
  xfer_t log_q[$];

  logic [31:0] smem [4];
  logic [31:0] last_wdata = '0;
  bit          hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e);
    rsp_t r;
    r.rdata = d;
    r.err = e;
    exp_q.push_back(r);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rsp_t e;
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL rsp_unexpected: rdata 0x%08h err %0b", rsp_rdata, rsp_error);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_error", 32'(rsp_error), 32'(e.err));
      end
    end
  end

  // Subordinate model plus address-hold protocol checks
  bit          dp_act = 1'b0;
  bit          dp_w = 1'b0;
  bit          dp_err = 1'b0;
  logic [3:0]  dp_addr = '0;
  int          dp_waits = 0;
  int          dp_ecnt = 0;
  bit          pv_stall = 1'b0;
  logic [3:0]  pv_addr = '0;
  logic [2:0]  pv_size = '0;
  logic        pv_w = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      dp_act = 1'b0;
      hready = 1'b1;
      hresp = 1'b0;
      hrdata = '0;
      pv_stall = 1'b0;
      cfg_q.delete();
    end else begin
      cfg_t c;
      xfer_t x;
      hresp = 1'b0;
      hrdata = '0;
      if (hold) begin
        hready = 1'b0;
      end else if (!dp_act) begin
        hready = 1'b1;
      end else if (dp_err) begin
        hresp = 1'b1;
        hready = (dp_ecnt == 1);
        if (dp_ecnt == 1) chk("err2_htrans", 32'(htrans), 32'd0);
        dp_ecnt++;
      end else if (dp_waits > 0) begin
        hready = 1'b0;
        dp_waits--;
      end else begin
        hready = 1'b1;
        if (dp_w) begin
          smem[dp_addr[3:2]] = hwdata;
          last_wdata = hwdata;
        end else begin
          hrdata = smem[dp_addr[3:2]];
        end
      end
      chk("hsel", 32'(hsel), 32'(htrans == 2'b10));
      chk("hburst", 32'(hburst), 32'd0);
      if (pv_stall) begin
        chk("hold_htrans", 32'(htrans), 32'd2);
        chk("hold_haddr", 32'(haddr), 32'(pv_addr));
        chk("hold_hsize", 32'(hsize), 32'(pv_size));
        chk("hold_hwrite", 32'(hwrite), 32'(pv_w));
      end
      pv_stall = !hready && !hresp && htrans == 2'b10;
      pv_addr = haddr;
      pv_size = hsize;
      pv_w = hwrite;
      if (hready) begin
        dp_act = (htrans == 2'b10);
        if (dp_act) begin
          x.addr = haddr;
          x.w = hwrite;
          x.size = hsize;
          x.cyc = cyc;
          log_q.push_back(x);
          dp_addr = haddr;
          dp_w = hwrite;
          dp_ecnt = 0;
          dp_waits = 0;
          dp_err = 1'b0;
          if (cfg_q.size() > 0) begin
            c = cfg_q.pop_front();
            dp_waits = c.waits;
            dp_err = c.err;
          end
        end
      end
    end
  end

  int acc_cyc = 0;

  task automatic send(input logic w, input logic [3:0] a,
                      input logic [2:0] s, input logic [31:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_size = s;
    cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL send_timeout: cmd_ready stuck at %0b", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL drain_timeout: %0d responses missing", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int a0;
    int m;
    smem[0] = 32'hA0A0A0A0;
    smem[1] = 32'h00000000;
    smem[2] = 32'h12345678;
    smem[3] = 32'hC3C3C3C3;
    repeat (3) @(negedge clk);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hsel", 32'(hsel), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_haddr", 32'(haddr), 32'd0);

    // Word write, no wait states
    n0 = log_q.size();
    expect_rsp(32'h0, 1'b0);
    send(1'b1, 4'h4, 3'd2, 32'hDEADBEEF);
    drain();
    chk("t1_nxfer", 32'(log_q.size() - n0), 32'd1);
    chk("t1_haddr", 32'(log_q[n0].addr), 32'h4);
    chk("t1_hwrite", 32'(log_q[n0].w), 32'd1);
    chk("t1_hsize", 32'(log_q[n0].size), 32'd2);
    chk("t1_hwdata", last_wdata, 32'hDEADBEEF);

    // Read latency when idle
    expect_rsp(32'hDEADBEEF, 1'b0);
    send(1'b0, 4'h4, 3'd2, 32'h0);
    a0 = acc_cyc;
    drain();
    chk("t1_rd_latency", 32'(rsp_cyc_q[$] - a0), 32'd3);

    // Read with three wait states
    n0 = log_q.size();
    cfg_q.push_back('{3, 1'b0});
    expect_rsp(32'h12345678, 1'b0);
    send(1'b0, 4'h8, 3'd2, 32'h0);
    a0 = acc_cyc;
    drain();
    chk("t2_haddr", 32'(log_q[n0].addr), 32'h8);
    chk("t2_hsize", 32'(log_q[n0].size), 32'd2);
    chk("t2_latency", 32'(rsp_cyc_q[$] - a0), 32'd6);

    // Fill the queue while stalled, then stream four reads
    @(posedge clk);
    #1 hold = 1'b1;
    n0 = log_q.size();
    expect_rsp(32'hA0A0A0A0, 1'b0);
    expect_rsp(32'hDEADBEEF, 1'b0);
    expect_rsp(32'h12345678, 1'b0);
    expect_rsp(32'hC3C3C3C3, 1'b0);
    send(1'b0, 4'h0, 3'd2, 32'h0);
    send(1'b0, 4'h4, 3'd2, 32'h0);
    send(1'b0, 4'h8, 3'd2, 32'h0);
    send(1'b0, 4'hC, 3'd2, 32'h0);
    chk("t3_full_ready", 32'(cmd_ready), 32'd0);
    hold = 1'b0;
    drain();
    chk("t3_nxfer", 32'(log_q.size() - n0), 32'd4);
    for (int i = 1; i < 4; i++)
      chk("t3_contig_nonseq", 32'(log_q[n0 + i].cyc - log_q[n0].cyc), 32'(i));
    m = rsp_cyc_q.size() - 4;
    for (int i = 1; i < 4; i++)
      chk("t3_rsp_b2b", 32'(rsp_cyc_q[m + i] - rsp_cyc_q[m]), 32'(i));

    // Two-cycle error on a write with a pipelined read behind it
    n0 = log_q.size();
    cfg_q.push_back('{0, 1'b1});
    cfg_q.push_back('{0, 1'b0});
    expect_rsp(32'h0, 1'b1);
    if (FLUSH) expect_rsp(32'h0, 1'b1);
    else expect_rsp(32'hDEADBEEF, 1'b0);
    send(1'b1, 4'h0, 3'd2, 32'h55555555);
    send(1'b0, 4'h4, 3'd2, 32'h0);
    drain();
    cfg_q.delete();
    chk("t4_nxfer", 32'(log_q.size() - n0), FLUSH ? 32'd1 : 32'd2);
    chk("t4_first_addr", 32'(log_q[n0].addr), 32'h0);

    // Misaligned halfword and illegal size between legal reads
    n0 = log_q.size();
    expect_rsp(32'hA0A0A0A0, 1'b0);
    expect_rsp(32'h0, 1'b1);
    expect_rsp(32'h12345678, 1'b0);
    expect_rsp(32'h0, 1'b1);
    send(1'b0, 4'h0, 3'd2, 32'h0);
    send(1'b0, 4'h3, 3'd1, 32'h0);
    send(1'b0, 4'h8, 3'd2, 32'h0);
    send(1'b0, 4'h4, 3'd3, 32'h0);
    drain();
    chk("t5_nxfer", 32'(log_q.size() - n0), 32'd2);
    chk("t5_addr0", 32'(log_q[n0].addr), 32'h0);
    chk("t5_addr1", 32'(log_q[n0 + 1].addr), 32'h8);

    // Reset during a wait-stated data phase
    cfg_q.push_back('{20, 1'b0});
    send(1'b0, 4'hC, 3'd2, 32'h0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_htrans", 32'(htrans), 32'd0);
    chk("t6_hsel", 32'(hsel), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    expect_rsp(32'hDEADBEEF, 1'b0);
    send(1'b0, 4'h4, 3'd2, 32'h0);
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
